// File: rtl/uart_cmd_decoder_pkg.sv
// Shared types and constants for the UART command decoder.
// The optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
package uart_cmd_pkg;

    // Frame parser states
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Width of the saturating dropped-frame counter
    localparam int ERR_W = 8;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and command output of the UART command decoder.
// master = harness side (drives bytes, accepts commands), slave = decoder.
interface uart_cmd_decoder_if #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BYTES = 2
);
    logic                    in_valid;
    logic [7:0]              in_data;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_BITS-1:0]    cmd_addr;
    logic [DATA_BYTES*8-1:0] cmd_data;

    modport master (
        output in_valid, in_data, cmd_ready,
        input  cmd_valid, cmd_addr, cmd_data
    );

    modport slave (
        input  in_valid, in_data, cmd_ready,
        output cmd_valid, cmd_addr, cmd_data
    );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap counter. Counts clocks since the last clear and flags
// expiry once the count reaches TIMEOUT_CLKS-1; it then holds there until
// cleared. Only used when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CLKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise count up and stick at LAST
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: hunts for SYNC_BYTE, assembles ADDR + DATA_BYTES
// payload bytes, checks the XOR checksum and presents good frames on a
// valid/ready command port. Bad, overrun and (optionally) timed-out frames
// are dropped and counted in err_count.
// Optional feature macro: UART_CMD_TIMEOUT_EN (inter-byte timeout).
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int         DATA_BYTES   = 2,
    parameter int         ADDR_BITS    = 8,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic             clk,
    input  logic             reset,
    uart_cmd_decoder_if.slave bus,
    output logic             chk_err,
    output logic             overrun,
    output logic [ERR_W-1:0] err_count
);
    localparam int DATA_W = DATA_BYTES * 8;
    localparam int IDX_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

    // Reject nonsensical parameterisations at elaboration time
    generate
        if (ADDR_BITS < 1 || ADDR_BITS > 8) begin : g_bad_addr_bits
            $error("uart_cmd_decoder: ADDR_BITS must be 1..8");
        end
        if (TIMEOUT_CLKS < 2) begin : g_bad_timeout
            $error("uart_cmd_decoder: TIMEOUT_CLKS must be >= 2");
        end
        if (DATA_BYTES < 1) begin : g_bad_data_bytes
            $error("uart_cmd_decoder: DATA_BYTES must be >= 1");
        end
    endgenerate

    // Parser state and shadow registers (independent of the output slot)
    state_t               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [ADDR_BITS-1:0] addr_sh_q,  addr_sh_d;
    logic [DATA_W-1:0]    data_sh_q,  data_sh_d;
    logic [7:0]           xor_q,      xor_d;

    // Output slot and status
    logic                 cmd_valid_q, cmd_valid_d;
    logic [ADDR_BITS-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0]    cmd_data_q,  cmd_data_d;
    logic                 chk_err_q,   chk_err_d;
    logic                 overrun_q,   overrun_d;
    logic [ERR_W-1:0]     err_count_q, err_count_d;

    logic err_inc;
    logic slot_free;
    logic timed_out;

`ifdef UART_CMD_TIMEOUT_EN
    logic to_clear;
    logic to_expired;

    // Counter runs only while a frame is in progress; any byte restarts it
    assign to_clear = bus.in_valid || (state_q == HUNT);

    uart_cmd_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .expired(to_expired)
    );

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign timed_out = to_expired && !bus.in_valid && (state_q != HUNT);
`else
    assign timed_out = 1'b0;
`endif

    // The slot can take a new command if empty or being drained this cycle
    assign slot_free = !cmd_valid_q || bus.cmd_ready;

    // Next-state logic for the parser, output slot and error reporting
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        xor_d       = xor_q;
        cmd_valid_d = cmd_valid_q && !bus.cmd_ready;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        chk_err_d   = 1'b0;
        overrun_d   = 1'b0;
        err_inc     = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.in_data == SYNC_BYTE) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_sh_d = bus.in_data[ADDR_BITS-1:0];
                    xor_d     = bus.in_data;
                    idx_d     = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    data_sh_d = (data_sh_q << 8) | DATA_W'(bus.in_data);
                    xor_d     = xor_q ^ bus.in_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                CHECK: begin
                    state_d = HUNT;
                    if (bus.in_data == xor_q) begin
                        if (slot_free) begin
                            cmd_valid_d = 1'b1;
                            cmd_addr_d  = addr_sh_q;
                            cmd_data_d  = data_sh_q;
                        end else begin
                            overrun_d = 1'b1;
                            err_inc   = 1'b1;
                        end
                    end else begin
                        chk_err_d = 1'b1;
                        err_inc   = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (timed_out) begin
            state_d = HUNT;
            err_inc = 1'b1;
        end

        err_count_d = err_count_q;
        if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // State and output registers; reset discards any partial frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            xor_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            chk_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            xor_q       <= xor_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            chk_err_q   <= chk_err_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign chk_err       = chk_err_q;
    assign overrun       = overrun_q;
    assign err_count     = err_count_q;

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command decoder downstream of the UART receiver in the test harness. Consumes one-cycle byte strobes, hunts for a sync byte, assembles an address plus a multi-byte data word, and checks an XOR checksum. Good frames are presented as a single command on a valid/ready interface to the harness register file. Bad, timed-out and overrun frames are dropped and reported.

## Interface
- `DATA_BYTES`, default 2: payload bytes per frame; `cmd_data` width is `DATA_BYTES*8`.
- `ADDR_BITS`, default 8: address width, 1..8; taken from the low bits of the address byte.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CLKS`, default 100000: maximum inter-byte gap within a frame, in clocks; must be ≥ 2.
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: one-cycle strobe, a byte is present; there is no backpressure.
- `in_data` in 8: received byte, sampled when `in_valid`=1.
- `cmd_valid` out 1: command available.
- `cmd_ready` in 1: consumer accepts the command when `cmd_valid && cmd_ready`.
- `cmd_addr` out ADDR_BITS: command address.
- `cmd_data` out DATA_BYTES*8: command data, first received byte in the MSBs.
- `chk_err` out 1: one-cycle pulse, checksum mismatch.
- `overrun` out 1: one-cycle pulse, good frame dropped because the output was still occupied.
- `err_count` out 8: saturating count of all dropped frames.

## Operation
- Frame format: SYNC, ADDR, D[0]..D[DATA_BYTES-1], CHK. D[0] is the MSB byte. CHK = ADDR ^ D[0] ^ … ^ D[N-1].
- States and transitions:
  - HUNT: a byte equal to SYNC_BYTE moves to ADDR; any other byte is ignored.
  - ADDR: the byte is stored and the running XOR is initialised to it; move to DATA with byte index 0.
  - DATA: the byte is shifted into the shadow data register and XORed in; after byte DATA_BYTES-1, move to CHECK.
  - CHECK: the byte is compared against the running XOR, then return to HUNT.
- A SYNC_BYTE value inside ADDR, DATA or CHECK is treated as ordinary data; there is no resync mid-frame.
- The shadow address/data registers are separate from the output registers, so parsing continues while a command is pending.
- At CHECK, on a match:
  - If the output slot is free, or is being accepted this same cycle, load the output registers and set `cmd_valid`.
  - Otherwise pulse `overrun`, increment `err_count`, and leave the pending command unchanged.
- At CHECK, on a mismatch: pulse `chk_err` and increment `err_count`.
- `cmd_valid` stays high and the outputs stay stable until a handshake occurs.
- `err_count` saturates at 255.
- Reset mid-frame discards the partial frame.

## Timing
- Reset values:
  - State is HUNT.
  - `cmd_valid`, `chk_err`, `overrun` are 0.
  - `cmd_addr`, `cmd_data`, `err_count` are 0.
- `cmd_valid` rises on the clock edge after the edge that samples the CHK `in_valid`. Latency is 1 cycle.
- `chk_err` and `overrun` are high for exactly the cycle after the CHK strobe.
- `cmd_valid` falls on the edge following the handshake, unless a new good frame loads on that same edge, in which case it stays high with new contents.
- The block must tolerate back-to-back `in_valid` on consecutive cycles.

## Configuration
- `UART_CMD_TIMEOUT_EN` defined:
  - In states other than HUNT, a counter is cleared on every `in_valid` and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 without a byte, the state returns to HUNT and `err_count` increments.
  - A byte arriving in the same cycle as expiry wins: the byte is processed and the counter is cleared.
- `UART_CMD_TIMEOUT_EN` not defined: no counter logic; a partial frame waits indefinitely.

## Structure
- Package `uart_cmd_pkg` holds:
  - the state enum (HUNT, ADDR, DATA, CHECK);
  - the default SYNC_BYTE constant;
  - the `err_count` width constant.
- Sub-module `uart_cmd_timeout`: the inter-byte timeout counter with `clear`/`expired` ports. It is instantiated only under `UART_CMD_TIMEOUT_EN`.

## Test plan
- Good frame: bytes A5, 12, 34, 56, 70 with `cmd_ready`=1 → one `cmd_valid` cycle, `cmd_addr`=12, `cmd_data`=3456, no error pulses.
- Bad checksum: A5, 12, 34, 56, 71 → `chk_err` pulse, no `cmd_valid`, `err_count`=1.
- Garbage then frame: 00, FF, A5, 01, 00, 02, 03 → only the A5 frame is decoded, giving `cmd_addr`=01 and `cmd_data`=0002.
- Overrun: `cmd_ready`=0, two back-to-back good frames → first command held stable, `overrun` pulse on the second, `err_count`=1. Raising `cmd_ready` then completes one handshake.
- Timeout (macro on, TIMEOUT_CLKS=50): A5, 12, then a 60-clock gap, then a good frame → first partial frame dropped with `err_count`=1, second frame decoded correctly.
- Reset asserted asynchronously between DATA bytes → all outputs return to 0 immediately, and the next full frame decodes correctly.
